// File: rtl/tele_word_serializer_pkg.sv
// tele_word_serializer_pkg: shared FSM states, line level and frame length helper.
package tele_word_serializer_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PAR, STOP} state_t;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int frame_bits(input int width, input int parity_en);
        return 2 + width + parity_en;
    endfunction

endpackage

// File: rtl/tele_word_serializer_bit_tick_det.sv
// tele_word_serializer_bit_tick_det: registered rising-edge detector turning the divided bit clock into a one-cycle tick.
module tele_word_serializer_bit_tick_det (
    input  logic clkIN,
    input  logic rstN,
    input  logic bitClkIN,
    output logic tickOUT
);

    logic bit_clk_q, bit_clk_d;

    always_comb bit_clk_d = bitClkIN;

    always_ff @(posedge clkIN) bit_clk_q <= rstN ? bit_clk_d : 1'b0;

    assign tickOUT = bitClkIN & ~bit_clk_q;

endmodule

// File: rtl/tele_word_serializer.sv
// tele_word_serializer: frames parallel words into start/data MSB-first/optional even parity/stop bits at the bit-tick rate.
module tele_word_serializer #(
    parameter int WIDTH     = 12,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clkIN,
    input  logic             rstN,
    input  logic             bitClkIN,
    input  logic [WIDTH-1:0] dataIN,
    input  logic             validIN,
    output logic             readyOUT,
    output logic             serOUT,
    output logic             busyOUT,
    output logic             doneOUT
);

    import tele_word_serializer_pkg::*;

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             ser_q, ser_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             tick;

    tele_word_serializer_bit_tick_det u_bit_tick_det (
        .clkIN   (clkIN),
        .rstN    (rstN),
        .bitClkIN(bitClkIN),
        .tickOUT (tick)
    );

    always_ff @(posedge clkIN) begin
        if (!rstN) begin
            state_q <= IDLE;
            ser_q   <= LINE_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ser_q   <= ser_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ser_d   = ser_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                ser_d = LINE_IDLE;
                if (validIN) begin
                    shift_d = dataIN;
                    par_d   = ^dataIN;
                    state_d = WAIT;
                end
            end
            WAIT: if (tick) begin
                state_d = START;
                ser_d   = 1'b0;
            end
            START: if (tick) begin
                state_d = DATA;
                ser_d   = shift_q[WIDTH-1];
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = CW'(WIDTH - 1);
            end
            DATA: if (tick) begin
                if (cnt_q != '0) begin
                    ser_d   = shift_q[WIDTH-1];
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    state_d = PARITY_EN ? PAR : STOP;
                    ser_d   = PARITY_EN ? par_q : LINE_IDLE;
                end
            end
            PAR: if (tick) begin
                state_d = STOP;
                ser_d   = LINE_IDLE;
            end
            STOP: if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        readyOUT = state_q == IDLE;
        busyOUT  = state_q != IDLE;
        doneOUT  = (state_q == STOP) && tick;
        serOUT   = ser_q;
    end

endmodule

// File: tb/tb_tele_word_serializer.sv
// tb_tele_word_serializer: random and directed frames checked against a bit-queue model of the line protocol.
module tb_tele_word_serializer;

    localparam int BIT_CYC = 21;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        bclk = 1'b0;
    int          div = 0;
    logic        ref_tick;
    logic [1:0]  valid = '0;
    logic [1:0]  ready, ser, busy, done;
    logic [11:0] data_in [2];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div  <= (div == BIT_CYC - 1) ? 0 : div + 1;
        bclk <= div < 10;
    end

    assign ref_tick = div == 1;

    tele_word_serializer #(.WIDTH(12), .PARITY_EN(1'b0)) u_nopar (
        .clkIN(clk), .rstN(rstN), .bitClkIN(bclk), .dataIN(data_in[0]), .validIN(valid[0]),
        .readyOUT(ready[0]), .serOUT(ser[0]), .busyOUT(busy[0]), .doneOUT(done[0])
    );

    tele_word_serializer #(.WIDTH(12), .PARITY_EN(1'b1)) u_par (
        .clkIN(clk), .rstN(rstN), .bitClkIN(bclk), .dataIN(data_in[1]), .validIN(valid[1]),
        .readyOUT(ready[1]), .serOUT(ser[1]), .busyOUT(busy[1]), .doneOUT(done[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send_frame(input int which, input logic [11:0] w, input logic nv, input logic [11:0] nd,
                              input int glitch_bit, input int rst_bit, output int acc_wait);
        logic q[$];
        int   bad, n, total;
        q = {};
        q.push_back(1'b0);
        for (int i = 11; i >= 0; i--) q.push_back(w[i]);
        if (which == 1) q.push_back(^w);
        q.push_back(1'b1);
        valid[which]   = 1'b1;
        data_in[which] = w;
        acc_wait = 0;
        while (!ready[which] && acc_wait < 1000) begin
            @(negedge clk);
            acc_wait++;
        end
        check($sformatf("accept_ready%0d", which), ready[which], 1);
        @(negedge clk);
        valid[which]   = nv;
        data_in[which] = nd;
        bad = 0;
        n = 0;
        while (!ref_tick && n < 40) begin
            bad += int'(ser[which] !== 1'b1 || ready[which] !== 1'b0 || busy[which] !== 1'b1);
            @(negedge clk);
            n++;
        end
        bad += int'(ser[which] !== 1'b1);
        check($sformatf("wait_line%0d", which), bad, 0);
        check($sformatf("wait_len_ok%0d", which), int'(n < BIT_CYC), 1);
        total = 0;
        for (int k = 0; k < q.size(); k++) begin
            bad = 0;
            for (int c = 1; c <= BIT_CYC; c++) begin
                @(negedge clk);
                total++;
                if (k == rst_bit && c == 5) begin
                    rstN = 1'b0;
                    @(negedge clk);
                    check("rst_ser", ser[which], 1);
                    check("rst_ready", ready[which], 1);
                    check("rst_busy", busy[which], 0);
                    rstN = 1'b1;
                    valid[which] = 1'b0;
                    return;
                end
                if (k == glitch_bit && c == 3) begin
                    valid[which]   = 1'b1;
                    data_in[which] = ~w;
                end
                if (k == glitch_bit && c == 4) valid[which] = 1'b0;
                bad += int'(ser[which] !== q[k] || ready[which] !== 1'b0 || busy[which] !== 1'b1 ||
                            done[which] !== (k == q.size() - 1 && c == BIT_CYC));
            end
            check($sformatf("w%0d_%03h_bit%0d", which, w, k), bad, 0);
        end
        check($sformatf("frame_cycles%0d", which), total, (2 + 12 + which) * BIT_CYC);
        @(negedge clk);
        check($sformatf("post_frame%0d", which),
              int'(ready[which] === 1'b1 && ser[which] === 1'b1 && busy[which] === 1'b0 && done[which] === 1'b0), 1);
    endtask

    initial begin
        int bad, w;
        data_in[0] = '0;
        data_in[1] = '0;
        repeat (3) @(negedge clk);
        check("reset_ser", ser, 3);
        check("reset_ready", ready, 3);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rstN = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            bad += int'(ser !== 2'b11 || ready !== 2'b11 || busy !== 2'b00 || done !== 2'b00);
        end
        check("idle200", bad, 0);
        send_frame(1, 12'hA5C, 1'b0, 12'h0, -1, -1, w);
        send_frame(1, 12'h001, 1'b0, 12'h0, -1, -1, w);
        send_frame(0, 12'h001, 1'b0, 12'h0, -1, -1, w);
        send_frame(1, 12'hFFF, 1'b1, 12'h000, -1, -1, w);
        send_frame(1, 12'h000, 1'b0, 12'h0, -1, -1, w);
        check("b2b_accept_wait", w, 0);
        send_frame(1, 12'($urandom), 1'b0, 12'h0, 7, -1, w);
        send_frame(1, 12'h3C7, 1'b0, 12'h0, -1, 6, w);
        send_frame(1, 12'h5A5, 1'b0, 12'h0, -1, -1, w);
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 25)) @(negedge clk);
            send_frame(int'($urandom_range(0, 1)), 12'($urandom), 1'b0, 12'h0, -1, -1, w);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
